// File: rtl/riscv_wb_pkg.sv
// Shared types for the writeback stage: source select, load size, FSM state,
// and the natural-alignment rule for loads.
package riscv_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2,
    LS_D = 2'd3
  } load_size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // Offset is zero-extended to 3 bits so the same rule serves XLEN 32 and 64.
  function automatic logic is_misaligned(load_size_e size, logic [2:0] off);
    logic mis;
    case (size)
      LS_B:    mis = 1'b0;
      LS_H:    mis = off[0];
      LS_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts a byte/half/word/double at a byte offset from an aligned XLEN-bit
// word and sign- or zero-extends it to XLEN. Purely combinational.
module load_align
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  i_data,
  input  logic [OFF_W-1:0] i_offset,
  input  load_size_e       i_size,
  input  logic             i_unsigned,
  output logic [XLEN-1:0]  o_data
);

  logic [XLEN-1:0] w_shifted;

  always_comb begin
    w_shifted = i_data >> {i_offset, 3'b000};
    case (i_size)
      LS_B:    o_data = i_unsigned ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
      LS_H:    o_data = i_unsigned ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
      LS_W:    o_data = i_unsigned ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Pipelined writeback stage: selects the result source, waits for load data,
// and drives a registered single write port into the register file.
module writeback_stage
  import riscv_wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_wb_sel,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc_incre,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [1:0]            in_load_size,
  input  logic                  in_load_unsigned,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  pend_valid,
  output logic [REG_ADDR_W-1:0] pend_rd,
  output logic                  misalign_err,
  output logic                  stray_rsp
);

  localparam int OFF_W = $clog2(XLEN / 8);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  load_size_e            r_size;
  logic                  r_unsigned;
  logic [OFF_W-1:0]      r_offset;

  wb_sel_e               w_sel;
  load_size_e            w_size;
  logic                  w_accept;
  logic                  w_misalign;
  logic [XLEN-1:0]       w_result;
  logic [XLEN-1:0]       w_load_data;

  assign w_sel      = wb_sel_e'(in_wb_sel);
  assign w_size     = load_size_e'(in_load_size);
  assign in_ready   = (r_state == ST_IDLE) & ~rst;
  assign w_accept   = in_valid & in_ready;
  assign w_misalign = is_misaligned(w_size, 3'(in_alu_result[OFF_W-1:0]));
  assign pend_valid = (r_state == ST_WAIT_MEM);
  assign pend_rd    = pend_valid ? r_rd : '0;

  always_comb begin
    case (w_sel)
      WB_PC4:  w_result = in_pc_incre;
      WB_IMM:  w_result = in_imm;
      default: w_result = in_alu_result;
    endcase
  end

  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .i_data     (mem_rsp_data),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept && w_sel == WB_MEM && !w_misalign) w_state_nxt = ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_rsp_valid) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // rf_waddr/rf_wdata only move on an actual write so they hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      stray_rsp    <= 1'b0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_size       <= LS_B;
      r_unsigned   <= 1'b0;
      r_offset     <= '0;
    end else begin
      rf_we        <= 1'b0;
      misalign_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_rsp_valid) stray_rsp <= 1'b1;
          if (w_accept) begin
            if (w_sel == WB_MEM) begin
              r_rd         <= in_rd;
              r_reg_write  <= in_reg_write;
              r_size       <= w_size;
              r_unsigned   <= in_load_unsigned;
              r_offset     <= in_alu_result[OFF_W-1:0];
              misalign_err <= w_misalign;
            end else if (in_reg_write && in_rd != '0) begin
              rf_we    <= 1'b1;
              rf_waddr <= in_rd;
              rf_wdata <= w_result;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rsp_valid && r_reg_write && r_rd != '0) begin
            rf_we    <= 1'b1;
            rf_waddr <= r_rd;
            rf_wdata <= w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level model of the stage.
module tb_writeback_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_wb_sel;
  logic            in_reg_write;
  logic [RW-1:0]   in_rd;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_incre;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_load_size;
  logic            in_load_unsigned;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            pend_valid;
  logic [RW-1:0]   pend_rd;
  logic            misalign_err;
  logic            stray_rsp;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_pc_incre(in_pc_incre), .in_imm(in_imm),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd),
    .misalign_err(misalign_err), .stray_rsp(stray_rsp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level model state
  bit          m_busy = 0, m_rw = 0, m_uns = 0, m_we = 0, m_mis = 0, m_stray = 0;
  int          m_rd = 0, m_size = 0, m_off = 0, m_waddr = 0;
  logic [31:0] m_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ext_load(logic [31:0] data, int off, int size, bit uns);
    longint unsigned v, mask;
    int bits;
    bits = 8 << size;
    v    = {32'b0, data};
    v    = v >> (8 * off);
    mask = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v    = v & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One clock: snapshot pre-edge inputs, advance the model, compare after the edge.
  task automatic tick();
    bit s_rst, s_valid, s_rw, s_uns, s_rsp;
    int s_sel, s_rd, s_size, bytes, off;
    logic [31:0] s_alu, s_pc, s_imm, s_data;
    @(negedge clk);
    s_rst = rst; s_valid = in_valid; s_sel = in_wb_sel; s_rw = in_reg_write;
    s_rd = in_rd; s_alu = in_alu_result; s_pc = in_pc_incre; s_imm = in_imm;
    s_size = in_load_size; s_uns = in_load_unsigned; s_rsp = mem_rsp_valid;
    s_data = mem_rsp_data;
    chk("in_ready", in_ready, !m_busy && !s_rst);
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      m_busy = 0; m_we = 0; m_mis = 0; m_stray = 0; m_waddr = 0; m_wdata = '0;
      m_rd = 0; m_rw = 0; m_size = 0; m_uns = 0; m_off = 0;
    end else begin
      m_we  = 0;
      m_mis = 0;
      if (!m_busy) begin
        if (s_rsp) m_stray = 1;
        if (s_valid) begin
          if (s_sel == 1) begin
            off   = int'(s_alu % 4);
            bytes = 1 << s_size;
            if (off % bytes != 0) m_mis = 1;
            else begin
              m_busy = 1; m_rd = s_rd; m_rw = s_rw; m_size = s_size;
              m_uns = s_uns; m_off = off;
            end
          end else if (s_rw && s_rd != 0) begin
            m_we = 1; m_waddr = s_rd;
            m_wdata = (s_sel == 0) ? s_alu : (s_sel == 2) ? s_pc : s_imm;
          end
        end
      end else if (s_rsp) begin
        m_busy = 0;
        if (m_rw && m_rd != 0) begin
          m_we = 1; m_waddr = m_rd;
          m_wdata = ext_load(s_data, m_off, m_size, m_uns);
        end
      end
    end
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("pend_valid", pend_valid, m_busy);
    if (m_busy) chk("pend_rd", pend_rd, m_rd);
    chk("misalign_err", misalign_err, m_mis);
    chk("stray_rsp", stray_rsp, m_stray);
  endtask

  task automatic clr();
    in_valid = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic issue(input int sel, input bit rw, input int rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] imm, input int size, input bit uns);
    in_valid = 1; in_wb_sel = 2'(sel); in_reg_write = rw; in_rd = RW'(rd);
    in_alu_result = alu; in_pc_incre = pc; in_imm = imm;
    in_load_size = 2'(size); in_load_unsigned = uns;
  endtask

  initial begin
    rst = 1; clr();
    issue(0, 0, 0, '0, '0, '0, 0, 0);
    in_valid = 0;
    tick(); tick();
    chk("rst_we", rf_we, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ready", in_ready, 0);
    rst = 0;

    // ALU write
    issue(0, 1, 5, 32'h1234, 32'h0, 32'h0, 0, 0);
    tick(); clr();
    chk("alu_we", rf_we, 1); chk("alu_addr", rf_waddr, 5); chk("alu_data", rf_wdata, 32'h1234);
    tick();
    chk("alu_pulse", rf_we, 0); chk("alu_hold", rf_wdata, 32'h1234);

    // jal to x0 and x1
    issue(2, 1, 0, 32'h0, 32'h104, 32'h0, 0, 0);
    tick(); clr();
    chk("x0_we", rf_we, 0);
    issue(2, 1, 1, 32'h0, 32'h104, 32'h0, 0, 0);
    tick(); clr();
    chk("jal_we", rf_we, 1); chk("jal_data", rf_wdata, 32'h104);

    // Signed byte load, three wait cycles
    issue(1, 1, 7, 32'h1003, 32'h0, 32'h0, 0, 0);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_ready", in_ready, 0); chk("ld_pend", pend_valid, 1); chk("ld_pend_rd", pend_rd, 7);
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h80FFFFFF;
    tick(); clr();
    chk("lb_we", rf_we, 1); chk("lb_data", rf_wdata, 32'hFFFFFF80); chk("lb_ready", in_ready, 1);

    // Unsigned half, then misaligned half
    issue(1, 1, 8, 32'h2002, 32'h0, 32'h0, 1, 1);
    tick(); clr();
    mem_rsp_valid = 1; mem_rsp_data = 32'hBEEF0000;
    tick(); clr();
    chk("lhu_data", rf_wdata, 32'h0000BEEF);
    issue(1, 1, 8, 32'h2003, 32'h0, 32'h0, 1, 1);
    tick(); clr();
    chk("mis_pulse", misalign_err, 1); chk("mis_we", rf_we, 0); chk("mis_ready", in_ready, 1);
    tick();
    chk("mis_clear", misalign_err, 0);

    // Back-to-back ALU, then a load stalls the port
    for (int i = 1; i <= 4; i++) begin
      issue(0, 1, i, 32'h100 + 32'(i), 32'h0, 32'h0, 0, 0);
      tick();
      chk("b2b_we", rf_we, 1); chk("b2b_addr", rf_waddr, i); chk("b2b_data", rf_wdata, 32'h100 + 32'(i));
    end
    issue(1, 1, 9, 32'h3000, 32'h0, 32'h0, 2, 0);
    tick();
    chk("b2b_stall", in_ready, 0);
    tick(); clr();
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    tick(); clr();
    chk("lw_data", rf_wdata, 32'hCAFEF00D);

    // Reset during a load, then a stray response
    issue(1, 1, 10, 32'h3000, 32'h0, 32'h0, 2, 0);
    tick(); clr();
    rst = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h12345678;
    tick(); clr(); rst = 0;
    chk("rstld_we", rf_we, 0); chk("rstld_pend", pend_valid, 0); chk("rstld_stray", stray_rsp, 0);
    tick();
    mem_rsp_valid = 1;
    tick(); clr();
    chk("stray_set", stray_rsp, 1);
    tick(); tick();
    chk("stray_sticky", stray_rsp, 1);
    rst = 1; tick(); rst = 0;
    chk("stray_rst", stray_rsp, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      in_valid         = $urandom_range(0, 1);
      in_wb_sel        = 2'($urandom_range(0, 3));
      in_reg_write     = ($urandom_range(0, 7) != 0);
      in_rd            = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
      in_alu_result    = $urandom;
      in_pc_incre      = $urandom;
      in_imm           = $urandom;
      in_load_size     = 2'($urandom_range(0, 2));
      in_load_unsigned = $urandom_range(0, 1);
      mem_rsp_valid    = ($urandom_range(0, 3) == 0);
      mem_rsp_data     = $urandom;
      tick();
    end
    rst = 0; clr(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised writeback stage for the pipelined RISC-V core, successor to the single-cycle writeback mux. It accepts one retiring instruction per handshake from the MEM stage and selects the result source: ALU, load data, PC+4 or immediate. For loads it waits any number of cycles for the memory response, then aligns and sign/zero-extends the returned data. It drives a registered one-write register-file port and exposes a pending-destination indication for hazard logic.

## Interface
- XLEN, 32, datapath width; must be 32 or 64
- REG_ADDR_W, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  MEM stage offers an instruction
- in_ready  out  1  stage can accept; handshake completes when in_valid & in_ready
- in_wb_sel  in  2  source select: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
- in_reg_write  in  1  instruction writes rd
- in_rd  in  REG_ADDR_W  destination register
- in_alu_result  in  XLEN  ALU result; for loads this is the byte address
- in_pc_incre  in  XLEN  PC+4
- in_imm  in  XLEN  immediate (lui)
- in_load_size  in  2  0 byte, 1 half, 2 word, 3 double (double legal only when XLEN=64)
- in_load_unsigned  in  1  zero-extend when 1, sign-extend when 0
- mem_rsp_valid  in  1  load data valid this cycle
- mem_rsp_data  in  XLEN  naturally aligned XLEN-bit word containing the load
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write index
- rf_wdata  out  XLEN  write data
- pend_valid  out  1  a load is outstanding
- pend_rd  out  REG_ADDR_W  rd of the outstanding load
- misalign_err  out  1  one-cycle pulse when an accepted load is misaligned
- stray_rsp  out  1  sticky flag: mem_rsp_valid was seen in IDLE

## Operation
- FSM states: IDLE and WAIT_MEM.
- in_ready = (state == IDLE) & ~rst. It is not combinationally dependent on mem_rsp_valid.
- IDLE, accept with in_wb_sel != 1:
  - Compute result: ALU, PC+4 or IMM.
  - Register rf_we = in_reg_write & (in_rd != 0), with rf_waddr = in_rd and rf_wdata = result.
  - Stay in IDLE.
- IDLE, accept with in_wb_sel == 1:
  - Latch rd, reg_write, size, unsigned and offset = in_alu_result[log2(XLEN/8)-1:0].
  - If misaligned, pulse misalign_err next cycle, do not write, and stay in IDLE.
  - Otherwise go to WAIT_MEM.
- Misaligned means: half with an odd offset, word with offset % 4 != 0, or double with offset != 0.
- WAIT_MEM:
  - pend_valid = 1, pend_rd = latched rd (even if rd is 0).
  - mem_rsp_valid low: hold state.
  - mem_rsp_valid high: extract the field at byte offset, extend it to XLEN per unsigned, register the write (gated by reg_write & rd != 0), and return to IDLE.
- mem_rsp_valid in IDLE is ignored for writing and sets stray_rsp. stray_rsp clears only on rst.
- rf_we is a one-cycle pulse. rf_waddr and rf_wdata hold their last values when rf_we is 0.
- x0 is never written: rf_we stays 0 whenever rd == 0.

## Timing
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, pend_valid 0, pend_rd 0, misalign_err 0, stray_rsp 0.
- Non-load latency: accept in cycle N, rf_we high in N+1.
- Load latency: response in cycle M, rf_we high in M+1. in_ready returns high in M+1.
- Throughput: one non-load per cycle. Loads block new input until the cycle after the response.
- At most one rf write per cycle, guaranteed by in_ready being low in WAIT_MEM.
- rst asserted in WAIT_MEM abandons the load. A response arriving in the cycle rst is high is dropped and does not set stray_rsp.

## Structure
- The package riscv_wb_pkg holds:
  - the wb_sel enum (WB_ALU, WB_MEM, WB_PC4, WB_IMM);
  - the load_size enum (LS_B, LS_H, LS_W, LS_D);
  - the FSM state enum.
- One sub-module, load_align: purely combinational, taking data, offset, size and unsigned, and returning the extended result. It is reusable by the future cache-bypass path.

## Test plan
- Reset and ALU write: accept sel=ALU, rd=5, alu=0x1234 → next cycle rf_we=1, waddr=5, wdata=0x1234; all outputs 0 during rst.
- x0 and jal: sel=PC4, rd=0, pc_incre=0x104 → rf_we stays 0. Same with rd=1 → wdata=0x104.
- Signed byte load: addr=0x1003, size=B, signed; after 3 wait cycles rsp_data=0x80FFFFFF → in_ready=0 and pend_valid=1, pend_rd=rd while waiting; rf_we one cycle after rsp, wdata=0xFFFFFF80.
- Unsigned half: addr=0x2002, size=H, unsigned, rsp=0xBEEF0000 → wdata=0x0000BEEF. Misaligned half at addr=0x2003 → misalign_err pulse, no write, in_ready stays 1.
- Back-to-back: 4 consecutive ALU instructions rd=1..4 → rf_we high for 4 consecutive cycles with matching data; an immediately following load stalls in_ready.
- Reset mid-load: rst in WAIT_MEM with rsp in the same cycle → no write, pend_valid=0. A later lone rsp in IDLE → stray_rsp=1, sticky until rst.
